botoes_condicionador: RTL
=========================

// Module: botoes_condicionador
// PURPOSE
//  Input stage directly upstream of Chill_Out: conditions the raw board buttons for the game FSM.
//  - Synchronises, debounces and edge-detects each button, then drives one-cycle press pulses on Chill_Out's inputs.
//  - Also drives a 2-bit colour code with valid, and a multi-press error.
//  - Optional inactivity timer provides the "lose by time" event.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000      stable cycles required to accept a level change (10 ms @ 50 MHz); >=2
//  TIMEOUT_CYCLES   250000000   armed cycles without a colour press before timeout (5 s @ 50 MHz); >=2
//  ACTIVE_LOW       1           1: raw pins read 0 when pressed; 0: read 1 when pressed
// PORTS
//  clock                 in   1  system clock
//  reset                 in   1  asynchronous, active-high
//  Raw_Vermelho          in   1  raw red button pin
//  Raw_Azul              in   1  raw blue button pin
//  Raw_Amarelo           in   1  raw yellow button pin
//  Raw_Verde             in   1  raw green button pin
//  Raw_Iniciar           in   1  raw start button pin
//  Raw_Ultima            in   1  raw replay-last-sequence button pin
//  Tempo_Armar           in   1  from game FSM: high while waiting for player input
//  Bot_Vermelho          out  1  1-cycle press pulse
//  Bot_Azul              out  1  1-cycle press pulse
//  Bot_Amarelo           out  1  1-cycle press pulse
//  Bot_Verde             out  1  1-cycle press pulse
//  Bot_Ultima_Sequencia  out  1  1-cycle press pulse
//  Iniciar_Jogo          out  1  debounced level, high while start is held
//  Cor_Codigo            out  2  colour of last accepted press: 00 Vermelho, 01 Azul, 10 Amarelo, 11 Verde
//  Cor_Valida            out  1  1-cycle pulse, concurrent with the accepted colour pulse
//  Multiplo_Erro         out  1  1-cycle pulse, rejected colour press
//  Tempo_Esgotado        out  1  1-cycle timeout pulse (tied 0 when feature compiled out)
// BEHAVIOUR
//  - Reset (async assert, sync release): all outputs 0, Cor_Codigo=00.
//    All button FSMs in SOLTO, counters 0, sync flops at released level.
//  - Sync: 2-FF synchroniser per raw pin. Polarity normalised after sync so 1 = pressed.
//  - Per-button FSM, 6 instances, each with a counter of width $clog2(DEBOUNCE_CYCLES+1):
//      SOLTO       -> CONF_PRESS   when sync=1; counter cleared
//      CONF_PRESS  -> SOLTO        if sync=0 (bounce); counter cleared
//                  -> PRESSIONADO  when counter == DEBOUNCE_CYCLES-1 and sync=1; raise press event
//      PRESSIONADO -> CONF_SOLTA   when sync=0; counter cleared
//      CONF_SOLTA  -> PRESSIONADO  if sync=1 (bounce); no new event
//                  -> SOLTO        when counter == DEBOUNCE_CYCLES-1 and sync=0
//  - Latency: a clean press sampled at edge N yields a registered pulse high in cycle N+2+DEBOUNCE_CYCLES.
//  - Exactly one pulse per press; holding a button never repeats the pulse.
//  - Iniciar_Jogo = 1 while the start FSM is in PRESSIONADO or CONF_SOLTA.
//  - Colour arbitration, per cycle:
//    - Exactly one colour event, with no other colour in PRESSIONADO/CONF_SOLTA:
//      - that colour's Bot_* pulse plus Cor_Valida;
//      - Cor_Codigo updated the same cycle and held until the next accepted press.
//    - Two or more colour events in the same cycle, or an event while another colour is held:
//      - no Bot_* pulse, no Cor_Valida;
//      - Multiplo_Erro pulse;
//      - Cor_Codigo unchanged.
//  - Bot_Ultima_Sequencia is independent of colour arbitration and may coincide with a colour pulse.
//  - Reset mid-debounce: the press is discarded. A button still held at release of reset must be released and re-pressed to produce a pulse.
// CONFIGURATION
//  BOTOES_TIMEOUT_EN defined:
//   - Timer width is $clog2(TIMEOUT_CYCLES+1).
//   - Timer counts every cycle while Tempo_Armar=1.
//   - Timer is cleared when Tempo_Armar=0 or Cor_Valida=1.
//   - On reaching TIMEOUT_CYCLES-1: Tempo_Esgotado pulses for 1 cycle, then the timer saturates. No further pulse until Tempo_Armar falls.
//   - Cor_Valida in the same cycle as expiry wins: timer clears, no timeout pulse.
//  BOTOES_TIMEOUT_EN undefined: no timer logic, Tempo_Esgotado tied 0, Tempo_Armar ignored. Port list is identical.
// TESTING (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20, ACTIVE_LOW=1)
//  1. Raw_Azul 1->0 held 10 cycles -> one Bot_Azul pulse 6 cycles after first sampling edge; Cor_Codigo=01, Cor_Valida same cycle.
//  2. Raw_Verde toggling 0,1,0,1 each cycle, then held 0 -> no pulse during bounce; single Bot_Verde pulse; Cor_Codigo=11.
//  3. Raw_Vermelho and Raw_Amarelo pressed on the same edge -> Multiplo_Erro pulse once; no Bot_* pulse; Cor_Codigo unchanged.
//  4. Hold Raw_Azul, then press Raw_Verde -> Multiplo_Erro on the Verde event; release both, press Verde alone -> Bot_Verde pulse.
//  5. Raw_Iniciar held 8 cycles -> Iniciar_Jogo high from cycle 6 until 6 cycles after release; reset asserted mid-hold -> Iniciar_Jogo=0 immediately.
//  6. BOTOES_TIMEOUT_EN defined, Tempo_Armar=1, no presses:
//     - Tempo_Esgotado pulses once at cycle 20; no repeat while still armed.
//     - Rearm, then Bot_Azul at cycle 15 -> no timeout at cycle 20.

Source files
------------

// File: rtl/botoes_condicionador.sv
// Button conditioner for the game FSM: sync, debounce, press-edge pulses, colour arbitration.
// Define BOTOES_TIMEOUT_EN to build the inactivity timer that drives Tempo_Esgotado.
module botoes_condicionador #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TIMEOUT_CYCLES  = 250000000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       Raw_Vermelho,
    input  logic       Raw_Azul,
    input  logic       Raw_Amarelo,
    input  logic       Raw_Verde,
    input  logic       Raw_Iniciar,
    input  logic       Raw_Ultima,
    input  logic       Tempo_Armar,
    output logic       Bot_Vermelho,
    output logic       Bot_Azul,
    output logic       Bot_Amarelo,
    output logic       Bot_Verde,
    output logic       Bot_Ultima_Sequencia,
    output logic       Iniciar_Jogo,
    output logic [1:0] Cor_Codigo,
    output logic       Cor_Valida,
    output logic       Multiplo_Erro,
    output logic       Tempo_Esgotado
);

    localparam int             CW         = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_ONE    = CW'(1);
    localparam logic [5:0]     IDLE_LEVEL = {6{ACTIVE_LOW}};

    localparam logic [1:0] SOLTO       = 2'd0;
    localparam logic [1:0] CONF_PRESS  = 2'd1;
    localparam logic [1:0] PRESSIONADO = 2'd2;
    localparam logic [1:0] CONF_SOLTA  = 2'd3;

    localparam int IDX_INICIAR = 4;
    localparam int IDX_ULTIMA  = 5;

    logic [5:0]          raw_s;
    logic [5:0]          sync1_q;
    logic [5:0]          sync2_q;
    logic [5:0]          pressed_s;
    logic [1:0]          settle_q;
    logic [1:0]          settle_d;
    logic [5:0]          armed_q;
    logic [5:0]          armed_d;
    logic [5:0][1:0]     st_q;
    logic [5:0][1:0]     st_d;
    logic [5:0][CW-1:0]  cnt_q;
    logic [5:0][CW-1:0]  cnt_d;
    logic [5:0]          ev_s;
    logic [3:0]          col_held_s;
    logic [3:0]          col_ev_s;
    logic                multi_s;
    logic                accept_s;
    logic                reject_s;
    logic [1:0]          cor_d;
    logic [1:0]          cor_q;
    logic [3:0]          bot_q;
    logic                valida_q;
    logic                erro_q;
    logic                ultima_q;
    logic                iniciar_q;

    assign raw_s     = {Raw_Ultima, Raw_Iniciar, Raw_Verde, Raw_Amarelo, Raw_Azul, Raw_Vermelho};
    assign pressed_s = ACTIVE_LOW ? ~sync2_q : sync2_q;

    // A button may only start a press once it has been seen released after reset,
    // so settle_q masks the synchroniser's reset value for its first two cycles.
    always_comb begin
        settle_d = {settle_q[0], 1'b1};
        armed_d  = armed_q | ({6{settle_q[1]}} & ~pressed_s);
    end

    // Per-button debounce FSMs and press events
    always_comb begin
        st_d       = st_q;
        cnt_d      = cnt_q;
        ev_s       = 6'b000000;
        col_held_s = 4'b0000;
        for (int b = 0; b < 6; b++) begin
            case (st_q[b])
                SOLTO: begin
                    if (pressed_s[b] && armed_q[b]) begin
                        st_d[b]  = CONF_PRESS;
                        cnt_d[b] = '0;
                    end else begin
                        st_d[b]  = SOLTO;
                    end
                end
                CONF_PRESS: begin
                    if (!pressed_s[b]) begin
                        st_d[b]  = SOLTO;
                        cnt_d[b] = '0;
                    end else if (cnt_q[b] == DB_LAST) begin
                        st_d[b]  = PRESSIONADO;
                        ev_s[b]  = 1'b1;
                    end else begin
                        cnt_d[b] = cnt_q[b] + CNT_ONE;
                    end
                end
                PRESSIONADO: begin
                    if (!pressed_s[b]) begin
                        st_d[b]  = CONF_SOLTA;
                        cnt_d[b] = '0;
                    end else begin
                        st_d[b]  = PRESSIONADO;
                    end
                end
                CONF_SOLTA: begin
                    if (pressed_s[b]) begin
                        st_d[b]  = PRESSIONADO;
                    end else if (cnt_q[b] == DB_LAST) begin
                        st_d[b]  = SOLTO;
                    end else begin
                        cnt_d[b] = cnt_q[b] + CNT_ONE;
                    end
                end
                default: begin
                    st_d[b]  = SOLTO;
                    cnt_d[b] = '0;
                end
            endcase
        end
        for (int c = 0; c < 4; c++) begin
            col_held_s[c] = (st_q[c] == PRESSIONADO) || (st_q[c] == CONF_SOLTA);
        end
    end

    // Colour arbitration: a lone event with no colour held is accepted, anything else is an error
    always_comb begin
        col_ev_s = ev_s[3:0];
        multi_s  = (col_ev_s & (col_ev_s - 4'd1)) != 4'd0;
        accept_s = (col_ev_s != 4'd0) && !multi_s && (col_held_s == 4'd0);
        reject_s = (col_ev_s != 4'd0) && !accept_s;
        cor_d    = cor_q;
        if (accept_s) begin
            case (col_ev_s)
                4'b0001: cor_d = 2'b00;
                4'b0010: cor_d = 2'b01;
                4'b0100: cor_d = 2'b10;
                4'b1000: cor_d = 2'b11;
                default: cor_d = cor_q;
            endcase
        end else begin
            cor_d = cor_q;
        end
    end

    // Synchronisers, FSM state and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q   <= IDLE_LEVEL;
            sync2_q   <= IDLE_LEVEL;
            settle_q  <= 2'b00;
            armed_q   <= 6'b000000;
            st_q      <= '0;
            cnt_q     <= '0;
            cor_q     <= 2'b00;
            bot_q     <= 4'b0000;
            valida_q  <= 1'b0;
            erro_q    <= 1'b0;
            ultima_q  <= 1'b0;
            iniciar_q <= 1'b0;
        end else begin
            sync1_q   <= raw_s;
            sync2_q   <= sync1_q;
            settle_q  <= settle_d;
            armed_q   <= armed_d;
            st_q      <= st_d;
            cnt_q     <= cnt_d;
            cor_q     <= cor_d;
            bot_q     <= accept_s ? col_ev_s : 4'b0000;
            valida_q  <= accept_s;
            erro_q    <= reject_s;
            ultima_q  <= ev_s[IDX_ULTIMA];
            iniciar_q <= (st_d[IDX_INICIAR] == PRESSIONADO) || (st_d[IDX_INICIAR] == CONF_SOLTA);
        end
    end

    assign Bot_Vermelho         = bot_q[0];
    assign Bot_Azul             = bot_q[1];
    assign Bot_Amarelo          = bot_q[2];
    assign Bot_Verde            = bot_q[3];
    assign Bot_Ultima_Sequencia = ultima_q;
    assign Iniciar_Jogo         = iniciar_q;
    assign Cor_Codigo           = cor_q;
    assign Cor_Valida           = valida_q;
    assign Multiplo_Erro        = erro_q;

`ifdef BOTOES_TIMEOUT_EN
    localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_SAT  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_ONE  = TW'(1);

    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic          esg_q;
    logic          esg_d;

    // Inactivity timer; parks at TO_SAT after firing so it pulses once per arming
    always_comb begin
        timer_d = timer_q;
        esg_d   = 1'b0;
        if (!Tempo_Armar || accept_s) begin
            timer_d = '0;
        end else if (timer_q == TO_LAST) begin
            timer_d = TO_SAT;
            esg_d   = 1'b1;
        end else if (timer_q == TO_SAT) begin
            timer_d = TO_SAT;
        end else begin
            timer_d = timer_q + TO_ONE;
        end
    end

    // Timer state and timeout pulse register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer_q <= '0;
            esg_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            esg_q   <= esg_d;
        end
    end

    assign Tempo_Esgotado = esg_q;
`else
    logic unused_armar_s;
    assign unused_armar_s = Tempo_Armar;
    assign Tempo_Esgotado = 1'b0;
`endif

endmodule
